fifo_rr_pop_arbiter: RTL and testbench
======================================

Name: fifo_rr_pop_arbiter

Overview:
- Shares one downstream consumer between NUM_FIFOS upstream fifo instances in the arbitrated_fifos datapath.
- Watches each fifo's empty flag and head data, and issues at most one pop per cycle using weighted round-robin (up to BURST consecutive pops per source).
- Registers the popped word into a single-entry output stage with a valid/ready handshake.
- Sits between the fifo bank and the consumer. It has no storage beyond the output register.

Parameters:
- NUM_FIFOS, 4, number of arbitrated fifos (>=2).
- WIDTH, 8, data width of each fifo entry.
- BURST, 1, maximum consecutive grants to one source before rotating (>=1; 1 = pure round-robin).
- SELW, $clog2(NUM_FIFOS), width of the source index.
- CNTW, $clog2(BURST+1), width of the burst counter.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-high.
- empty  input  NUM_FIFOS  per-fifo empty flag; bit i belongs to fifo i.
- enable  input  NUM_FIFOS  per-source arbitration enable (configuration, quasi-static).
- fifo_data  input  NUM_FIFOS*WIDTH  concatenated fifo head data; slice i is [i*WIDTH +: WIDTH].
- pop  output  NUM_FIFOS  one-hot or zero pop strobes, combinational.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  consumer accepts the word this cycle.
- out_data  output  WIDTH  registered word.
- out_sel  output  SELW  index of the source of out_data.

Behaviour:
- Reset (rst=1 at posedge): out_valid=0, out_data=0, out_sel=0, cur=NUM_FIFOS-1, cnt=0. pop is forced 0 in any cycle where rst=1.
- eligible = ~empty & enable.
- load = ~out_valid | out_ready.
- stay = (cnt != 0) & (cnt < BURST) & eligible[cur].
- Grant g:
  - If stay, g = cur.
  - Otherwise g = the first index with eligible set, scanning cur+1, cur+2, ... modulo NUM_FIFOS (cur itself is checked last).
- Pop: pop = onehot(g) only when load & (eligible != 0) & ~rst; otherwise pop = 0.
- Never pop a fifo whose empty=1 or enable=0. Never assert more than one pop bit.
- On a pop cycle:
  - Next cycle: out_valid=1, out_data = fifo_data slice g (sampled in the pop cycle, since fifo head data is combinational), out_sel = g.
  - If g == cur and stay: cnt <= cnt+1. Otherwise cur <= g and cnt <= 1.
- load=1, nothing eligible:
  - out_valid <= 0.
  - cnt <= 0, which breaks any burst.
  - cur is unchanged.
- load=0 (out_valid=1, out_ready=0): pop=0; out_data, out_sel, cur and cnt all hold.
- Latency: pop cycle N gives out_valid in cycle N+1.
- Throughput: one word per cycle while out_ready=1 and eligible != 0.
- A word is transferred when out_valid & out_ready. With the same cycle's pop, the register is refilled back-to-back with no bubble.
- Burst end: once cnt reaches BURST, the next grant scans from cur+1. If cur is the only eligible source, it is re-granted and cnt restarts at 1.
- Burst cut short: if eligible[cur] drops mid-burst, arbitration switches immediately by scanning from cur+1.
- Changing enable is legal at any time and takes effect on the same cycle's pop decision. out_data already registered is never discarded.
- Reset mid-operation: any registered word is dropped, and the first grant after reset goes to the lowest eligible index.
- Width rules:
  - Modulo wrap of cur+k is done in SELW+1 bits, then reduced.
  - cnt saturates at BURST and never wraps.

Test Plan:
1. NUM_FIFOS=4, BURST=1, all fifos nonempty, enable=4'hF, out_ready=1 -> pop one-hot sequence 0,1,2,3,0,1. out_sel follows one cycle later. out_valid stays 1 after the first cycle.
2. Backpressure: out_valid=1 with out_data=8'hA5, drive out_ready=0 for 3 cycles -> pop=0 and out_data=8'hA5 stable all 3 cycles. When out_ready returns to 1, the pop for the next source occurs in that same cycle.
3. BURST=3, only fifos 0 and 2 nonempty -> grant order 0,0,0,2,2,2,0.
4. BURST=3, fifo 0 goes empty after 2 pops while fifos 1 and 3 are nonempty -> third grant is fifo 1, with cnt=1.
5. enable=4'b1101, all nonempty -> fifo 1 never popped; sequence 0,2,3,0. Then all fifos empty -> out_valid drops to 0 one cycle after the last transfer, with pop=0.
6. rst=1 for one cycle mid-burst with out_valid=1 -> pop=0 during the rst cycle, out_valid=0 the cycle after. The first grant afterwards goes to fifo 0 when all fifos are nonempty.

Source files
------------

// File: rtl/fifo_rr_pop_arbiter_if.sv
// Bundle between the fifo bank / consumer and the round-robin pop arbiter.
// Handshake: the arbiter drives out_valid/out_data/out_sel from its output
// register; a word moves to the consumer in every cycle where
// out_valid && out_ready are both high at posedge. The consumer may hold
// out_ready low indefinitely; while it does, the word and its source are held.
// pop is a combinational strobe back to the fifos: at most one bit set, and
// only for a fifo that is non-empty and enabled in that same cycle.
// dbg_cur / dbg_cnt expose the arbiter's last granted source and burst count.
interface fifo_rr_pop_arbiter_if #(
    parameter int NUM_FIFOS = 4,
    parameter int WIDTH     = 8,
    parameter int BURST     = 1,
    parameter int SELW      = $clog2(NUM_FIFOS),
    parameter int CNTW      = $clog2(BURST + 1)
);
    logic [NUM_FIFOS-1:0]       empty;
    logic [NUM_FIFOS-1:0]       enable;
    logic [NUM_FIFOS*WIDTH-1:0] fifo_data;
    logic [NUM_FIFOS-1:0]       pop;
    logic                       out_valid;
    logic                       out_ready;
    logic [WIDTH-1:0]           out_data;
    logic [SELW-1:0]            out_sel;
    logic [SELW-1:0]            dbg_cur;
    logic [CNTW-1:0]            dbg_cnt;

    // Arbiter side.
    modport slave (
        input  empty, enable, fifo_data, out_ready,
        output pop, out_valid, out_data, out_sel, dbg_cur, dbg_cnt
    );

    // Fifo bank / consumer side.
    modport master (
        output empty, enable, fifo_data, out_ready,
        input  pop, out_valid, out_data, out_sel, dbg_cur, dbg_cnt
    );
endinterface

// File: rtl/fifo_rr_pop_arbiter.sv
// Weighted round-robin pop arbiter: picks at most one non-empty, enabled fifo
// per cycle (up to BURST consecutive grants per source), pops it and registers
// the head word into a single-entry valid/ready output stage.
// The module parameters must match the ones the bus interface was built with.
module fifo_rr_pop_arbiter #(
    parameter int NUM_FIFOS = 4,
    parameter int WIDTH     = 8,
    parameter int BURST     = 1,
    parameter int SELW      = $clog2(NUM_FIFOS),
    parameter int CNTW      = $clog2(BURST + 1)
) (
    input logic                 clk,
    input logic                 rst,
    fifo_rr_pop_arbiter_if.slave bus
);

    localparam logic [CNTW-1:0] BURST_C = CNTW'(BURST);
    localparam logic [SELW:0]   NUM_C   = (SELW+1)'(NUM_FIFOS);

    logic                 out_valid_q;
    logic [WIDTH-1:0]     out_data_q;
    logic [SELW-1:0]      out_sel_q;
    logic [SELW-1:0]      cur;
    logic [CNTW-1:0]      cnt;

    logic [NUM_FIFOS-1:0] eligible;
    logic                 any_eligible;
    logic                 load;
    logic                 stay;
    logic                 pop_go;
    logic [SELW-1:0]      scan_sel;
    logic [SELW:0]        wrap;
    logic [SELW-1:0]      grant;

    assign eligible     = ~bus.empty & bus.enable;
    assign any_eligible = |eligible;
    assign load         = ~out_valid_q | bus.out_ready;
    assign stay         = (cnt != '0) && (cnt < BURST_C) && eligible[cur];

    // Rotating scan starting after cur; iterating from the far end lets the
    // nearest eligible index win without an early exit. cur is checked last.
    always_comb begin
        scan_sel = cur;
        wrap     = '0;
        for (int k = NUM_FIFOS; k >= 1; k--) begin
            wrap = {1'b0, cur} + (SELW+1)'(k);
            if (wrap >= NUM_C) begin
                wrap = wrap - NUM_C;
            end
            if (eligible[wrap[SELW-1:0]]) begin
                scan_sel = wrap[SELW-1:0];
            end
        end
    end

    assign grant  = stay ? cur : scan_sel;
    assign pop_go = load & any_eligible & ~rst;

    // Pop strobe: one-hot on the grant only when the output stage can take it.
    always_comb begin
        bus.pop = '0;
        if (pop_go) begin
            bus.pop = NUM_FIFOS'(1) << grant;
        end
    end

    // Output register and arbitration state (last source, burst length).
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            cur         <= SELW'(NUM_FIFOS - 1);
            cnt         <= '0;
        end else if (load) begin
            if (any_eligible) begin
                out_valid_q <= 1'b1;
                out_data_q  <= bus.fifo_data[grant*WIDTH +: WIDTH];
                out_sel_q   <= grant;
                if (stay) begin
                    cnt <= cnt + CNTW'(1);
                end else begin
                    cur <= grant;
                    cnt <= CNTW'(1);
                end
            end else begin
                // Nothing to pop: drain the stage and break any burst.
                out_valid_q <= 1'b0;
                cnt         <= '0;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;
    assign bus.dbg_cur   = cur;
    assign bus.dbg_cnt   = cnt;

endmodule

// File: tb/tb_fifo_rr_pop_arbiter.sv
// Bench for fifo_rr_pop_arbiter: two instances (BURST=1 and BURST=3) share
// the same stimulus; each is compared every cycle against a reference model
// of the grant rules, plus directed checks of the expected grant sequences.
module tb_fifo_rr_pop_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    // ---------------- clock / reset / stimulus signals ----------------
    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  empty;
    logic [N-1:0]  enable;
    logic [N*W-1:0] fifo_data;
    logic          out_ready;

    always #5 clk = ~clk;

    fifo_rr_pop_arbiter_if #(.NUM_FIFOS(N), .WIDTH(W), .BURST(1)) b1 ();
    fifo_rr_pop_arbiter_if #(.NUM_FIFOS(N), .WIDTH(W), .BURST(3)) b3 ();

    assign b1.empty     = empty;
    assign b1.enable    = enable;
    assign b1.fifo_data = fifo_data;
    assign b1.out_ready = out_ready;
    assign b3.empty     = empty;
    assign b3.enable    = enable;
    assign b3.fifo_data = fifo_data;
    assign b3.out_ready = out_ready;

    fifo_rr_pop_arbiter #(.NUM_FIFOS(N), .WIDTH(W), .BURST(1)) u_b1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    fifo_rr_pop_arbiter #(.NUM_FIFOS(N), .WIDTH(W), .BURST(3)) u_b3 (
        .clk (clk),
        .rst (rst),
        .bus (b3)
    );

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    // Per instance: held word, last granted source, length of current run.
    int           m_burst [2] = '{1, 3};
    logic         m_valid [2];
    logic [W-1:0] m_data  [2];
    int           m_sel   [2];
    int           m_last  [2];
    int           m_run   [2];

    logic [18:0]  obs [2];

    function automatic bit model_stay(int inst);
        logic [N-1:0] elig;
        elig = ~empty & enable;
        return (m_run[inst] > 0) && (m_run[inst] < m_burst[inst]) && elig[m_last[inst]];
    endfunction

    function automatic int model_grant(int inst);
        logic [N-1:0] elig;
        elig = ~empty & enable;
        if (model_stay(inst)) return m_last[inst];
        for (int k = 1; k <= N; k++) begin
            if (elig[(m_last[inst] + k) % N]) return (m_last[inst] + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_pop(int inst);
        int g;
        g = model_grant(inst);
        if (rst || (m_valid[inst] && !out_ready) || g < 0) return '0;
        return N'(1 << g);
    endfunction

    function automatic logic [18:0] model_obs(int inst);
        return {model_pop(inst), m_valid[inst], m_data[inst], 2'(m_sel[inst]),
                2'(m_last[inst]), 2'(m_run[inst])};
    endfunction

    task automatic model_step();
        int g;
        bit st;
        for (int d = 0; d < 2; d++) begin
            g  = model_grant(d);
            st = model_stay(d);
            if (rst) begin
                m_valid[d] = 1'b0;
                m_data[d]  = '0;
                m_sel[d]   = 0;
                m_last[d]  = N - 1;
                m_run[d]   = 0;
            end else if (!m_valid[d] || out_ready) begin
                if (g >= 0) begin
                    m_valid[d] = 1'b1;
                    m_data[d]  = fifo_data[g*W +: W];
                    m_sel[d]   = g;
                    m_run[d]   = st ? m_run[d] + 1 : 1;
                    m_last[d]  = g;
                end else begin
                    m_valid[d] = 1'b0;
                    m_run[d]   = 0;
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change after negedge; sample settles 1 time unit later.
    task automatic sample();
        #1;
        obs[0] = {b1.pop, b1.out_valid, b1.out_data, b1.out_sel, b1.dbg_cur, 1'b0, b1.dbg_cnt};
        obs[1] = {b3.pop, b3.out_valid, b3.out_data, b3.out_sel, b3.dbg_cur, b3.dbg_cnt};
    endtask

    task automatic advance();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        sample();
        advance();
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; empty = '1; enable = '1; out_ready = 1'b1; fifo_data = $urandom;
        sample();
        n_cmp++;
        if (b1.pop !== 4'b0000 || b3.pop !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_pop: got %b/%b required 0000", b1.pop, b3.pop);
        end
        advance();
        rst = 1'b0;
        sample();
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (obs[d][14:0] !== {1'b0, 8'h00, 2'd0, 2'd3, 2'd0}) begin
                n_err++;
                $display("FAIL reset_state inst%0d: got %h required %h", d, obs[d][14:0], 15'h000c);
            end
        end
        advance();
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_seq [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        empty = '0; enable = '1; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            fifo_data = $urandom;
            sample();
            n_cmp++;
            if (b1.pop !== exp_seq[i]) begin
                n_err++;
                $display("FAIL rr_pop step%0d: got %b required %b", i, b1.pop, exp_seq[i]);
            end
            if (i > 0) begin
                n_cmp++;
                if (b1.out_valid !== 1'b1 || b1.out_sel !== 2'((i - 1) % N)) begin
                    n_err++;
                    $display("FAIL rr_sel step%0d: got v=%b sel=%0d required v=1 sel=%0d",
                             i, b1.out_valid, b1.out_sel, (i - 1) % N);
                end
            end
            for (int d = 0; d < 2; d++) begin
                n_cmp++;
                if (obs[d] !== model_obs(d)) begin
                    n_err++;
                    $display("FAIL rr_model inst%0d step%0d: got %h required %h", d, i, obs[d], model_obs(d));
                end
            end
            advance();
        end
    endtask

    task automatic test_backpressure();
        fifo_data = {4{8'hA5}};
        out_ready = 1'b1;
        sample();
        n_cmp++;
        if (b1.pop !== 4'b0100) begin
            n_err++;
            $display("FAIL bp_load: got %b required 0100", b1.pop);
        end
        advance();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fifo_data = $urandom;
            sample();
            n_cmp++;
            if (b1.pop !== 4'b0000 || b1.out_data !== 8'hA5 || b3.pop !== 4'b0000 || b3.out_data !== 8'hA5) begin
                n_err++;
                $display("FAIL bp_hold cyc%0d: got pop=%b/%b data=%h/%h required 0000 a5",
                         i, b1.pop, b3.pop, b1.out_data, b3.out_data);
            end
            for (int d = 0; d < 2; d++) begin
                n_cmp++;
                if (obs[d] !== model_obs(d)) begin
                    n_err++;
                    $display("FAIL bp_model inst%0d cyc%0d: got %h required %h", d, i, obs[d], model_obs(d));
                end
            end
            advance();
        end
        out_ready = 1'b1;
        sample();
        n_cmp++;
        if (b1.pop !== 4'b1000 || b1.out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release: got pop=%b v=%b required 1000 v=1", b1.pop, b1.out_valid);
        end
        advance();
    endtask

    task automatic test_burst();
        logic [N-1:0] exp_seq [7] = '{4'b0001, 4'b0001, 4'b0001, 4'b0100, 4'b0100, 4'b0100, 4'b0001};
        enable = '1; out_ready = 1'b1; empty = '0;
        pulse_reset();
        empty = 4'b1010;
        for (int i = 0; i < 7; i++) begin
            fifo_data = $urandom;
            sample();
            n_cmp++;
            if (b3.pop !== exp_seq[i]) begin
                n_err++;
                $display("FAIL burst_pop step%0d: got %b required %b", i, b3.pop, exp_seq[i]);
            end
            for (int d = 0; d < 2; d++) begin
                n_cmp++;
                if (obs[d] !== model_obs(d)) begin
                    n_err++;
                    $display("FAIL burst_model inst%0d step%0d: got %h required %h", d, i, obs[d], model_obs(d));
                end
            end
            advance();
        end
    endtask

    task automatic test_burst_cut();
        enable = '1; out_ready = 1'b1; empty = '0;
        pulse_reset();
        empty = 4'b0100;
        for (int i = 0; i < 2; i++) begin
            fifo_data = $urandom;
            sample();
            n_cmp++;
            if (b3.pop !== 4'b0001) begin
                n_err++;
                $display("FAIL cut_head step%0d: got %b required 0001", i, b3.pop);
            end
            advance();
        end
        empty = 4'b0101;
        sample();
        n_cmp++;
        if (b3.pop !== 4'b0010) begin
            n_err++;
            $display("FAIL cut_switch: got %b required 0010", b3.pop);
        end
        advance();
        sample();
        n_cmp++;
        if (b3.dbg_cur !== 2'd1 || b3.dbg_cnt !== 2'd1 || b3.out_sel !== 2'd1) begin
            n_err++;
            $display("FAIL cut_count: got cur=%0d cnt=%0d sel=%0d required 1 1 1",
                     b3.dbg_cur, b3.dbg_cnt, b3.out_sel);
        end
        advance();
    endtask

    task automatic test_enable_mask();
        logic [N-1:0] exp_seq [4] = '{4'b0001, 4'b0100, 4'b1000, 4'b0001};
        enable = '1; out_ready = 1'b1; empty = '0;
        pulse_reset();
        enable = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            fifo_data = $urandom;
            sample();
            n_cmp++;
            if (b1.pop !== exp_seq[i]) begin
                n_err++;
                $display("FAIL mask_pop step%0d: got %b required %b", i, b1.pop, exp_seq[i]);
            end
            advance();
        end
        empty = '1;
        sample();
        n_cmp++;
        if (b1.pop !== 4'b0000 || b1.out_valid !== 1'b1 || b3.pop !== 4'b0000) begin
            n_err++;
            $display("FAIL drain_last: got pop=%b/%b v=%b required 0000 v=1", b1.pop, b3.pop, b1.out_valid);
        end
        advance();
        sample();
        n_cmp++;
        if (b1.out_valid !== 1'b0 || b3.out_valid !== 1'b0 || b1.pop !== 4'b0000) begin
            n_err++;
            $display("FAIL drain_empty: got v=%b/%b pop=%b required v=0 pop=0000",
                     b1.out_valid, b3.out_valid, b1.pop);
        end
        advance();
    endtask

    task automatic test_reset_mid();
        enable = '1; out_ready = 1'b1; empty = '0;
        for (int i = 0; i < 2; i++) begin
            fifo_data = $urandom;
            sample();
            advance();
        end
        rst = 1'b1;
        sample();
        n_cmp++;
        if (b1.pop !== 4'b0000 || b3.pop !== 4'b0000 || b3.out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_pop: got pop=%b/%b v=%b required 0000 v=1", b1.pop, b3.pop, b3.out_valid);
        end
        advance();
        rst = 1'b0;
        sample();
        n_cmp++;
        if (b1.out_valid !== 1'b0 || b3.out_valid !== 1'b0 || b1.pop !== 4'b0001 || b3.pop !== 4'b0001) begin
            n_err++;
            $display("FAIL rstmid_after: got v=%b/%b pop=%b/%b required v=0 pop=0001",
                     b1.out_valid, b3.out_valid, b1.pop, b3.pop);
        end
        advance();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 49) == 0);
            empty     = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            enable    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            out_ready = ($urandom_range(0, 3) != 0);
            fifo_data = $urandom;
            sample();
            for (int d = 0; d < 2; d++) begin
                n_cmp++;
                if (obs[d] !== model_obs(d)) begin
                    n_err++;
                    $display("FAIL rand_model inst%0d cyc%0d: got %h required %h", d, i, obs[d], model_obs(d));
                end
            end
            advance();
        end
        rst = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        for (int d = 0; d < 2; d++) begin
            m_valid[d] = 1'b0;
            m_data[d]  = '0;
            m_sel[d]   = 0;
            m_last[d]  = N - 1;
            m_run[d]   = 0;
        end
        test_reset();
        test_round_robin();
        test_backpressure();
        test_burst();
        test_burst_cut();
        test_enable_mask();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
